msrv32_wb_stage: RTL
====================

// Module: msrv32_wb_stage
// PURPOSE
//  Write-back stage directly upstream of the integer register file.
//  - Accepts one retiring instruction per handshake and selects its result: ALU, load data, PC+4 or CSR.
//  - Stalls on loads until the data memory returns.
//  - Aligns and extends load data.
//  - Drives the register file write port (rd_addr/rd/wr_en) as a registered one-cycle pulse.
// PARAMETERS
//  XLEN       32  datapath width (only 32 supported)
//  INSTRET_W  64  width of retired-instruction counter (MSRV32_WB_INSTRET_EN only)
// PORTS
//  ms_risc32_mp_clk_in   in   1     core clock, rising edge
//  ms_risc32_mp_rst_in   in   1     one clock; reset is asynchronous and active-low
//  wb_valid_in           in   1     retiring instruction present
//  wb_ready_out          out  1     stage can accept (1 in IDLE, 0 in WAIT_MEM)
//  wb_rd_addr_in         in   5     destination register
//  wb_wr_en_in           in   1     instruction writes rd
//  wb_src_sel_in         in   2     00 ALU, 01 LOAD, 10 PC+4, 11 CSR
//  wb_funct3_in          in   3     load type (LB/LH/LW/LBU/LHU)
//  wb_addr_lsb_in        in   2     load effective address [1:0]
//  alu_result_in         in   32    ALU result
//  pc_plus4_in           in   32    link value for JAL/JALR
//  csr_data_in           in   32    CSR read data
//  dmem_rvalid_in        in   1     load data valid
//  dmem_rdata_in         in   32    raw word from data memory
//  rd_addr_out           out  5     to register file rd_addr_in
//  rd_out                out  32    to register file rd_in
//  wr_en_out             out  1     to register file wr_en_in, one-cycle pulse
//  load_misaligned_out   out  1     one-cycle pulse, misaligned load detected
//  instret_out           out  64    retired count (macro only)
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; rd_addr_out=0, rd_out=0, wr_en_out=0, load_misaligned_out=0, instret=0.
//    wb_ready_out=1 during and after reset.
//  - Accept = wb_valid_in & wb_ready_out.
//  - Sideband capture: rd_addr, wr_en, funct3, lsb are captured at accept; upstream may change them afterwards.
//  - Non-load accept (sel!=01): result is registered.
//    wr_en_out=wb_wr_en_in & (rd!=0) on the next edge, so latency is 1 cycle. State stays IDLE; back-to-back accepts are allowed.
//  - Load accept: state goes to WAIT_MEM and ready drops the next cycle.
//  - Misaligned load, checked at accept: LH/LHU with lsb=11, or LW with lsb!=00.
//    load_misaligned_out pulses next cycle, there is no write, state stays IDLE, and no memory wait occurs.
//  - WAIT_MEM: on dmem_rvalid_in, extract data, set rd_out and wr_en_out on the next edge, and return to IDLE.
//    ready reasserts in the same cycle as the wr_en_out pulse.
//  - Extraction:
//    - byte = rdata[8*lsb+:8]
//    - half = rdata[16*lsb[1]+:16]
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//    - Undefined funct3 (011, 11x) writes 0.
//  - dmem_rvalid_in in IDLE is ignored.
//  - wr_en_out is never high for more than one cycle per instruction and never for rd=0.
//  - rd_addr_out/rd_out hold their last value while wr_en_out=0.
//  - Reset mid-load: WAIT_MEM is abandoned, no write is issued, and a late rvalid is ignored.
//  - The register file bypasses rd_in when wr_en is set, so no extra forwarding is needed here.
// CONFIGURATION
//  MSRV32_WB_INSTRET_EN defined:
//    - 64-bit counter; +1 per completed instruction (non-load accept, load rvalid).
//    - Writing and non-writing instructions both count; misaligned loads are not counted.
//    - Wraps at 2^64; driven on instret_out.
//  Undefined: no counter, and the instret_out port is absent.
// STRUCTURE
//  msrv32_pkg:
//    - WB_SRC_ALU/LOAD/PC4/CSR
//    - F3_LB/LH/LW/LBU/LHU
//    - WB_ST_IDLE/WB_ST_WAIT_MEM
//  Sub-module msrv32_load_align: combinational (funct3, lsb, rdata) -> {data, misaligned}.
//  Top holds the FSM, output registers and counter.
// TESTING
//  1. ALU op, rd=5, alu=0xDEADBEEF, wr_en=1 -> next cycle wr_en_out=1, rd_addr_out=5, rd_out=0xDEADBEEF; then wr_en_out=0.
//  2. rd=0 with wr_en=1 and sel=PC4 -> wr_en_out stays 0; instret +1 with macro.
//  3. LB lsb=3, rdata=0x80FF_1234, rvalid after 3 cycles -> ready low 3 cycles, then rd_out=0xFFFFFF80.
//     Repeat as LBU -> 0x00000080.
//  4. LH lsb=3 -> load_misaligned_out 1-cycle pulse, no wr_en_out, ready stays 1.
//  5. Back-to-back ALU ops rd=1..4 on consecutive cycles -> four consecutive wr_en_out pulses with matching data.
//  6. Reset asserted in WAIT_MEM, rvalid arrives after release -> no write, all outputs 0, instret=0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared write-back stage definitions: result source selects, load funct3 codes, FSM states.
package msrv32_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_LOAD = 2'b01,
    WB_SRC_PC4  = 2'b10,
    WB_SRC_CSR  = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_ST_IDLE     = 1'b0,
    WB_ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational load data extraction (byte/half/word select, sign/zero extend)
// and misalignment detection.
module msrv32_load_align
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata[{lsb, 3'b000} +: 8];
    half_v     = rdata[{lsb[1], 4'b0000} +: 16];
    data       = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = '0;
    endcase
    misaligned = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && (lsb == 2'b11)) ||
                 ((funct3 == F3_LW) && (lsb != 2'b00));
  end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Write-back stage: result select, load wait FSM, registered register-file write pulse.
// Optional retired-instruction counter on instret_out when MSRV32_WB_INSTRET_EN is defined.
module msrv32_wb_stage
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic            ms_risc32_mp_clk_in,
  input  logic            ms_risc32_mp_rst_in,
  input  logic            wb_valid_in,
  output logic            wb_ready_out,
  input  logic [4:0]      wb_rd_addr_in,
  input  logic            wb_wr_en_in,
  input  logic [1:0]      wb_src_sel_in,
  input  logic [2:0]      wb_funct3_in,
  input  logic [1:0]      wb_addr_lsb_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic            dmem_rvalid_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_out,
  output logic            wr_en_out,
  output logic            load_misaligned_out
`ifdef MSRV32_WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret_out
`endif
);

  if (XLEN != 32 || INSTRET_W == 0) begin : g_cfg_check
    $error("msrv32_wb_stage: only XLEN=32 and nonzero INSTRET_W are supported");
  end

  wb_state_e       state, state_nxt;
  logic            accept, is_load, load_done;
  logic [4:0]      cap_rd;
  logic            cap_wr_en;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_lsb;
  logic [2:0]      al_funct3;
  logic [1:0]      al_lsb;
  logic [XLEN-1:0] al_data;
  logic            al_mis;
  logic [XLEN-1:0] sel_result;

  assign wb_ready_out = (state == WB_ST_IDLE);
  assign accept       = wb_valid_in & wb_ready_out;
  assign is_load      = (wb_src_sel_in == WB_SRC_LOAD);
  assign load_done    = (state == WB_ST_WAIT_MEM) & dmem_rvalid_in;

  // One aligner serves both uses: live sideband for the misalign check at
  // accept, captured sideband for data extraction while waiting on memory.
  assign al_funct3 = wb_ready_out ? wb_funct3_in   : cap_funct3;
  assign al_lsb    = wb_ready_out ? wb_addr_lsb_in : cap_lsb;

  msrv32_load_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .lsb        (al_lsb),
    .rdata      (dmem_rdata_in),
    .data       (al_data),
    .misaligned (al_mis)
  );

  always_comb begin
    sel_result = '0;
    case (wb_src_e'(wb_src_sel_in))
      WB_SRC_ALU: sel_result = alu_result_in;
      WB_SRC_PC4: sel_result = pc_plus4_in;
      WB_SRC_CSR: sel_result = csr_data_in;
      default:    sel_result = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_ST_IDLE:     if (accept && is_load && !al_mis) state_nxt = WB_ST_WAIT_MEM;
      WB_ST_WAIT_MEM: if (dmem_rvalid_in) state_nxt = WB_ST_IDLE;
      default:        state_nxt = WB_ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
    if (!ms_risc32_mp_rst_in) begin
      state               <= WB_ST_IDLE;
      cap_rd              <= '0;
      cap_wr_en           <= 1'b0;
      cap_funct3          <= '0;
      cap_lsb             <= '0;
      rd_addr_out         <= '0;
      rd_out              <= '0;
      wr_en_out           <= 1'b0;
      load_misaligned_out <= 1'b0;
    end else begin
      state               <= state_nxt;
      wr_en_out           <= 1'b0;
      load_misaligned_out <= 1'b0;
      if (accept) begin
        cap_rd     <= wb_rd_addr_in;
        cap_wr_en  <= wb_wr_en_in;
        cap_funct3 <= wb_funct3_in;
        cap_lsb    <= wb_addr_lsb_in;
      end
      if (accept && !is_load) begin
        if (wb_wr_en_in && (wb_rd_addr_in != 5'd0)) begin
          rd_addr_out <= wb_rd_addr_in;
          rd_out      <= sel_result;
          wr_en_out   <= 1'b1;
        end
      end else if (accept && is_load && al_mis) begin
        load_misaligned_out <= 1'b1;
      end
      if (load_done && cap_wr_en && (cap_rd != 5'd0)) begin
        rd_addr_out <= cap_rd;
        rd_out      <= al_data;
        wr_en_out   <= 1'b1;
      end
    end
  end

`ifdef MSRV32_WB_INSTRET_EN
  always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
    if (!ms_risc32_mp_rst_in) begin
      instret_out <= '0;
    end else if ((accept && !is_load) || load_done) begin
      instret_out <= instret_out + 1'b1;
    end
  end
`endif

endmodule
